// File: rtl/ps2_mouse_stream_controller.sv
// PS/2 mouse host: sends INIT_CMD, checks for the 0xFA ack, then streams PACKET_BYTES-byte movement packets.
// Optional build macro PS2_RETRY_EN: on a failed handshake, resend the command up to MAX_RETRY times.
module ps2_mouse_stream_controller #(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned PACKET_BYTES = 3,
  parameter logic [7:0]  INIT_CMD     = 8'hF4,
  parameter int unsigned FILTER_LEN   = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  output logic                      ps2_clk_hiz,
  output logic                      ps2_data_hiz,
  output logic [8*PACKET_BYTES-1:0] packet,
  output logic                      data_ready,
  output logic                      frame_error,
  output logic                      error_no_ack
);
  localparam int unsigned T150 = 32'((64'(CLK_FREQ_HZ) * 64'd150   + 64'd999_999) / 64'd1_000_000);
  localparam int unsigned T400 = 32'((64'(CLK_FREQ_HZ) * 64'd400   + 64'd999_999) / 64'd1_000_000);
  localparam int unsigned T20M = 32'((64'(CLK_FREQ_HZ) * 64'd20000 + 64'd999_999) / 64'd1_000_000);
  localparam int unsigned TW   = $clog2(T20M);
  localparam int unsigned FCW  = $clog2(FILTER_LEN + 1);
  localparam int unsigned BIW  = $clog2(PACKET_BYTES);
  localparam int unsigned PW   = 8 * PACKET_BYTES;

  typedef enum logic [3:0] {
    S_START, S_HOLD_CLK_L, S_REQ_SEND, S_TRANSMIT, S_ACK_BIT, S_WAIT_RESP,
    S_RX_IDLE, S_RX_FRAME, S_VERIFY, S_OUTPUT, S_ERROR
  } state_t;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, fall_q;
  logic [FCW-1:0] fcnt_q;

  state_t         state_q, state_d;
  logic [10:0]    tx_sh_q, tx_sh_d;
  logic [9:0]     rx_sh_q, rx_sh_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [PW-1:0]  pkt_buf_q, pkt_buf_d, packet_q, packet_d;
  logic           bad_q, bad_d;
  logic           data_ready_q, data_ready_d, frame_error_q, frame_error_d;
  logic           no_ack_q, no_ack_d, clk_hiz_q, clk_hiz_d, data_hiz_q, data_hiz_d;
  logic           hs_fail, rx_timeout, frame_ok;
  logic [10:0]    frame;
`ifdef PS2_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0]  retry_q, retry_d;
`endif

  // The filtered clock only follows the synchronised pad after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1; clk_s2_q <= 1'b1; dat_s1_q <= 1'b1; dat_s2_q <= 1'b1;
      filt_q   <= 1'b1; fall_q   <= 1'b0; fcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk;  clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data; dat_s2_q <= dat_s1_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
        fall_q <= 1'b0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
        fall_q <= ~clk_s2_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
        fall_q <= 1'b0;
      end
    end
  end

  assign frame    = {dat_s2_q, rx_sh_q};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_comb begin
    state_d       = state_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    byte_idx_d    = byte_idx_q;
    tmr_d         = tmr_q + 1'b1;
    pkt_buf_d     = pkt_buf_q;
    bad_d         = bad_q;
    packet_d      = packet_q;
    data_ready_d  = 1'b0;
    frame_error_d = 1'b0;
    no_ack_d      = no_ack_q;
    hs_fail       = 1'b0;
    rx_timeout    = 1'b0;
`ifdef PS2_RETRY_EN
    retry_d       = retry_q;
`endif
    case (state_q)
      S_START: begin
        tx_sh_d   = {1'b1, ~^INIT_CMD, INIT_CMD, 1'b0};
        tmr_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_HOLD_CLK_L;
      end
      S_HOLD_CLK_L: if (tmr_q == TW'(T150 - 1)) state_d = S_REQ_SEND;
      S_REQ_SEND:   state_d = S_TRANSMIT;
      S_TRANSMIT: if (fall_q) begin
        tx_sh_d   = {1'b1, tx_sh_q[10:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 4'd9) state_d = S_ACK_BIT;
      end
      S_ACK_BIT: if (fall_q) begin
        if (!dat_s2_q) begin
          state_d   = S_WAIT_RESP;
          bit_cnt_d = '0;
          tmr_d     = '0;
        end else begin
          hs_fail = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (fall_q) begin
          rx_sh_d   = {dat_s2_q, rx_sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (fall_q && bit_cnt_q == 4'd10) begin
          if (frame_ok && frame[8:1] == 8'hFA) begin
            state_d    = S_RX_IDLE;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
            bad_d      = 1'b0;
          end else begin
            hs_fail = 1'b1;
          end
        end else if (tmr_q == TW'(T20M - 1)) begin
          hs_fail = 1'b1;
        end
      end
      S_RX_IDLE: begin
        if (fall_q) begin
          rx_sh_d   = {dat_s2_q, rx_sh_q[9:1]};
          bit_cnt_d = 4'd1;
          tmr_d     = '0;
          state_d   = S_RX_FRAME;
        end else if (byte_idx_q != '0 && tmr_q == TW'(T400)) begin
          rx_timeout = 1'b1;
        end
      end
      S_RX_FRAME: begin
        if (fall_q) begin
          rx_sh_d   = {dat_s2_q, rx_sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          tmr_d     = '0;
          if (bit_cnt_q == 4'd10) begin
            pkt_buf_d[{byte_idx_q, 3'b000} +: 8] = frame[8:1];
            bad_d     = bad_q | ~frame_ok;
            bit_cnt_d = '0;
            if (byte_idx_q == BIW'(PACKET_BYTES - 1)) begin
              state_d = S_VERIFY;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
              state_d    = S_RX_IDLE;
            end
          end
        end else if (tmr_q == TW'(T400)) begin
          rx_timeout = 1'b1;
        end
      end
      S_VERIFY: begin
        byte_idx_d = '0;
        bad_d      = 1'b0;
        if (bad_q || !pkt_buf_q[3]) begin
          frame_error_d = 1'b1;
          state_d       = S_RX_IDLE;
        end else begin
          packet_d     = pkt_buf_q;
          data_ready_d = 1'b1;
          state_d      = S_OUTPUT;
        end
      end
      S_OUTPUT: state_d = S_RX_IDLE;
      S_ERROR:  no_ack_d = 1'b1;
      default:  state_d = S_START;
    endcase

    if (rx_timeout) begin
      frame_error_d = 1'b1;
      state_d       = S_RX_IDLE;
      byte_idx_d    = '0;
      bit_cnt_d     = '0;
      bad_d         = 1'b0;
    end

    if (hs_fail) begin
`ifdef PS2_RETRY_EN
      if (retry_q == RW'(MAX_RETRY)) begin
        state_d  = S_ERROR;
        no_ack_d = 1'b1;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_START;
      end
`else
      state_d  = S_ERROR;
      no_ack_d = 1'b1;
`endif
    end

    // Pad controls are registered from the next state so they never glitch.
    clk_hiz_d  = (state_d != S_HOLD_CLK_L);
    data_hiz_d = (state_d == S_REQ_SEND) ? 1'b0 :
                 (state_d == S_TRANSMIT) ? tx_sh_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_START;
      tx_sh_q       <= '1;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      byte_idx_q    <= '0;
      tmr_q         <= '0;
      pkt_buf_q     <= '0;
      bad_q         <= 1'b0;
      packet_q      <= '0;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      no_ack_q      <= 1'b0;
      clk_hiz_q     <= 1'b1;
      data_hiz_q    <= 1'b1;
`ifdef PS2_RETRY_EN
      retry_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_idx_q    <= byte_idx_d;
      tmr_q         <= tmr_d;
      pkt_buf_q     <= pkt_buf_d;
      bad_q         <= bad_d;
      packet_q      <= packet_d;
      data_ready_q  <= data_ready_d;
      frame_error_q <= frame_error_d;
      no_ack_q      <= no_ack_d;
      clk_hiz_q     <= clk_hiz_d;
      data_hiz_q    <= data_hiz_d;
`ifdef PS2_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign ps2_clk_hiz  = clk_hiz_q;
  assign ps2_data_hiz = data_hiz_q;
  assign packet       = packet_q;
  assign data_ready   = data_ready_q;
  assign frame_error  = frame_error_q;
  assign error_no_ack = no_ack_q;
endmodule

// File: tb/tb_ps2_mouse_stream_controller.sv
// Bench: behavioural PS/2 device model drives the pads; a compare process checks outputs every cycle.
module tb_ps2_mouse_stream_controller;
  localparam int unsigned CLK_HZ = 1_000_000;  // 1 cycle per microsecond
  localparam int unsigned PB     = 3;
  localparam int unsigned FL     = 8;
  localparam logic [7:0]  CMD    = 8'hF4;
  localparam int unsigned MAXR   = 3;
  localparam int unsigned T150   = 150;
  localparam int unsigned T400   = 400;
  localparam int unsigned HALF   = 20;
  localparam int unsigned GAP    = 60;
`ifdef PS2_RETRY_EN
  localparam int EXP_TX = MAXR + 1;
`else
  localparam int EXP_TX = 1;
`endif

  typedef struct {
    bit            is_dr;
    int            lo;
    int            hi;
    logic [8*PB-1:0] pkt;
  } ev_t;

  logic clk = 1'b0, reset = 1'b0, dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk, ps2_data, ps2_clk_hiz, ps2_data_hiz, data_ready, frame_error, error_no_ack;
  logic [8*PB-1:0] packet;

  assign ps2_clk  = dev_clk & ps2_clk_hiz;
  assign ps2_data = dev_data & ps2_data_hiz;

  ps2_mouse_stream_controller #(
    .CLK_FREQ_HZ(CLK_HZ), .PACKET_BYTES(PB), .INIT_CMD(CMD), .FILTER_LEN(FL), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_hiz(ps2_clk_hiz), .ps2_data_hiz(ps2_data_hiz), .packet(packet),
    .data_ready(data_ready), .frame_error(frame_error), .error_no_ack(error_no_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int last_fall = 0;
  bit chk_en = 1'b0;
  ev_t evq[$];
  ev_t pend;
  logic [8*PB-1:0] model_pkt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (chk_en) begin
      if (evq.size() > 0 && evq[0].is_dr && cyc == evq[0].lo) model_pkt = evq[0].pkt;
      chk("packet", 64'(packet), 64'(model_pkt));
      if (data_ready || frame_error) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {62'd0, data_ready, frame_error}, 64'd0);
        end else begin
          e = evq.pop_front();
          chk("pulse_kind", {62'd0, data_ready, frame_error}, e.is_dr ? 64'd2 : 64'd1);
          chk("pulse_cycle", 64'(cyc), (cyc < e.lo) ? 64'(e.lo) : (cyc > e.hi) ? 64'(e.hi) : 64'(cyc));
        end
      end else if (evq.size() > 0 && cyc > evq[0].hi) begin
        e = evq.pop_front();
        chk("missed_pulse", {62'd0, data_ready, frame_error}, e.is_dr ? 64'd2 : 64'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic bp, input logic bs,
                           input int nbits, input bit push);
    logic [10:0] fr;
    ev_t e;
    fr = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data = fr[i];
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk   = 1'b0;
      last_fall = cyc;
      if (push && i == 10) begin
        e = pend;
        e.lo = last_fall + pend.lo;
        e.hi = last_fall + pend.hi;
        evq.push_back(e);
      end
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  // ab_j < 0: full packet; otherwise stop after ab_k bits of byte ab_j and idle past the timeout.
  task automatic send_packet(input logic [8*PB-1:0] bytes, input logic [PB-1:0] bp,
                             input logic [PB-1:0] bs, input int ab_j, input int ab_k,
                             input int idle);
    ev_t e;
    bit good;
    good = (bp == '0) && (bs == '0) && bytes[3];
    pend = '{good, 4 + FL, 4 + FL, bytes};
    for (int j = 0; j < PB; j++) begin
      if (j == ab_j) begin
        send_byte(bytes[8*j +: 8], 1'b0, 1'b0, ab_k, 1'b0);
        break;
      end
      send_byte(bytes[8*j +: 8], bp[j], bs[j], 11, (ab_j < 0) && (j == PB - 1));
      if (j != PB - 1) repeat (GAP) @(posedge clk);
    end
    if (ab_j >= 0) begin
      e = '{1'b0, last_fall + 2 + FL + T400, last_fall + 6 + FL + T400, '0};
      evq.push_back(e);
      repeat (T400 + 100) @(posedge clk);
    end
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic wait_rts(input int budget, output bit found, output int hold);
    found = 1'b0;
    hold  = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (!ps2_clk_hiz) hold++;
      else if (!ps2_data_hiz) found = 1'b1;
    end
  endtask

  task automatic host_tx(input bit ack, output logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      repeat (HALF) @(posedge clk);
      #1;
      bits[i] = ps2_data;
      if (i == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int hold, n_tx, aj, ak, sel;
    logic [10:0] bits;
    logic [8*PB-1:0] bytes;
    logic [PB-1:0] bp, bs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_hiz", 64'(ps2_clk_hiz), 64'd1);
    chk("rst_data_hiz", 64'(ps2_data_hiz), 64'd1);
    chk("rst_packet", 64'(packet), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_frame_error", 64'(frame_error), 64'd0);
    chk("rst_no_ack", 64'(error_no_ack), 64'd0);

    // Device never acknowledges the command.
    @(negedge clk);
    reset = 1'b1;
    n_tx  = 0;
    do begin
      wait_rts(400, found, hold);
      if (found) begin
        n_tx++;
        host_tx(1'b0, bits);
      end
    end while (found && n_tx < 10);
    chk("noack_tx_count", 64'(n_tx), 64'(EXP_TX));
    chk("noack_flag", 64'(error_no_ack), 64'd1);
    chk("noack_clk_hiz", 64'(ps2_clk_hiz), 64'd1);
    chk("noack_data_hiz", 64'(ps2_data_hiz), 64'd1);

    // Clean handshake.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_no_ack", 64'(error_no_ack), 64'd0);
    reset = 1'b1;
    wait_rts(400, found, hold);
    chk("rts_seen", 64'(found), 64'd1);
    chk("hold_cycles", 64'(hold), 64'(T150));
    host_tx(1'b1, bits);
    chk("tx_frame_literal", 64'(bits), 64'(11'b1_0_11110100_0));
    chk("tx_frame_model", 64'(bits), 64'({1'b1, ~^CMD, CMD, 1'b0}));
    repeat (GAP) @(posedge clk);
    send_byte(8'hFA, 1'b0, 1'b0, 11, 1'b0);
    repeat (GAP) @(posedge clk);
    #1;
    chk("ack_no_error", 64'(error_no_ack), 64'd0);
    chk_en = 1'b1;

    send_packet(24'hFB0508, '0, '0, -1, 0, GAP);
    chk("pkt_fb0508", 64'(packet), 64'h0FB0508);
    send_packet(24'h221108, 3'b010, '0, -1, 0, GAP);
    chk("pkt_kept", 64'(packet), 64'h0FB0508);
    send_packet(24'h443318, '0, '0, -1, 0, 600);
    chk("pkt_443318", 64'(packet), 64'h0443318);
    send_packet(24'h007708, '0, '0, 1, 5, GAP);
    send_packet(24'h020109, '0, '0, -1, 0, GAP);
    chk("pkt_020109", 64'(packet), 64'h0020109);
    send_packet(24'h3C2A00, '0, '0, -1, 0, GAP);
    chk("pkt_nosync_kept", 64'(packet), 64'h0020109);

    for (int r = 0; r < 20; r++) begin
      bytes = (8*PB)'($urandom);
      sel   = int'($urandom_range(0, 9));
      bp = '0; bs = '0; aj = -1; ak = 0;
      case (sel)
        0: bp[$urandom_range(0, PB - 1)] = 1'b1;
        1: bs[$urandom_range(0, PB - 1)] = 1'b1;
        2: begin
          aj = int'($urandom_range(0, PB - 1));
          ak = (aj == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 10));
        end
        3: bytes[3] = 1'b0;
        default: bytes[3] = 1'b1;
      endcase
      send_packet(bytes, bp, bs, aj, ak, int'($urandom_range(GAP, 500)));
    end
    repeat (20) @(posedge clk);
    #1;
    chk("events_drained", 64'(evq.size()), 64'd0);

    // Reset in the middle of a packet.
    send_byte(8'h08, 1'b0, 1'b0, 11, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 4, 1'b0);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("midrst_clk_hiz", 64'(ps2_clk_hiz), 64'd1);
    chk("midrst_data_hiz", 64'(ps2_data_hiz), 64'd1);
    chk("midrst_packet", 64'(packet), 64'd0);
    chk("midrst_data_ready", 64'(data_ready), 64'd0);
    chk("midrst_frame_error", 64'(frame_error), 64'd0);
    chk("midrst_no_ack", 64'(error_no_ack), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("restart_hold", 64'(ps2_clk_hiz), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_stream_controller.md
# ps2_mouse_stream_controller

Parametrised successor to the PS/2 mouse interface controller. It integrates the line filter, bit shifter and the 150 µs/400 µs timers in one block. It sends a configurable init command, checks for the 0xFA acknowledge, then receives N-byte movement packets with per-byte frame/parity checking and inter-bit timeout resynchronisation. It sits between the PS/2 pads (open-drain, via hi-Z controls) and the cursor/game-input logic.

## Interface
- CLK_FREQ_HZ, 25_000_000, system clock frequency; all timer terminal counts derive from it
- PACKET_BYTES, 3, bytes per movement packet; legal values 3 or 4
- INIT_CMD, 8'hF4, command byte sent after reset (enable data reporting)
- FILTER_LEN, 8, consecutive equal samples required before filtered ps2_clk changes
- MAX_RETRY, 3, command resends before declaring no-ack (used only with PS2_RETRY_EN)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ps2_clk  in  1  raw PS/2 clock pad value
- ps2_data  in  1  raw PS/2 data pad value
- ps2_clk_hiz  out  1  1 = release clock line, 0 = drive low
- ps2_data_hiz  out  1  1 = release data line, 0 = drive low
- packet  out  8*PACKET_BYTES  last good packet; byte 0 in [7:0]; stable between data_ready pulses
- data_ready  out  1  one-cycle pulse when packet updates
- frame_error  out  1  one-cycle pulse on bad start/stop/parity or inter-bit timeout
- error_no_ack  out  1  sticky; set on failed command handshake, cleared only by reset

## Operation
- Input path: two-flop synchroniser on both lines. Filtered ps2_clk changes only after FILTER_LEN equal samples. A filtered high-to-low transition gives a one-cycle `fall` strobe; data is sampled on `fall`.
- States: START -> HOLD_CLK_L -> REQ_SEND -> TRANSMIT -> ACK_BIT -> WAIT_RESP -> RX_IDLE <-> RX_FRAME -> VERIFY -> OUTPUT; plus ERROR.
- START: both lines released; load shift register with {stop 1, odd parity of INIT_CMD, INIT_CMD, start 0}; go to HOLD_CLK_L.
- HOLD_CLK_L: clk driven low, data released, for 150 µs.
- REQ_SEND: data driven low, clk released, for one cycle; then TRANSMIT.
- TRANSMIT: on each `fall`, shift out the next bit, LSB first. ps2_data_hiz = current bit. After 10 falls the stop bit is on the line; go to ACK_BIT.
- ACK_BIT: on the 11th `fall`, sample data. Low goes to WAIT_RESP; high is a handshake failure.
- WAIT_RESP: receive one 11-bit frame. Byte 0xFA with valid framing goes to RX_IDLE. Any other byte, bad framing, or 20 ms without a complete frame is a handshake failure.
- Handshake failure: go to ERROR (error_no_ack=1, both lines released, terminal until reset).
- RX_IDLE/RX_FRAME: collect PACKET_BYTES frames. Per frame: start=0, stop=1, odd parity over data+parity bit.
- Inter-bit timeout: a gap >400 µs between `fall` strobes inside a frame or packet pulses frame_error and returns to RX_IDLE with the byte index at 0.
- VERIFY: bad framing in any byte pulses frame_error and drops the whole packet. A good packet goes to OUTPUT.
- OUTPUT: load packet, pulse data_ready, return to RX_IDLE.
- Byte 0 bit 3 must be 1 (mouse sync bit). If it is 0, drop the packet, pulse frame_error, and resync.

## Timing
- Reset values: ps2_clk_hiz=1, ps2_data_hiz=1, packet=0, data_ready=0, frame_error=0, error_no_ack=0, state=START, timers and counters 0.
- Timer counts are ceil(t·CLK_FREQ_HZ/1e6) cycles; counter width = $clog2 of the 20 ms count.
- `fall` occurs 2 + FILTER_LEN cycles after the raw pad edge.
- data_ready rises exactly 2 cycles after the `fall` that samples the last stop bit (VERIFY, then OUTPUT).
- frame_error is always a single-cycle pulse, never coincident with data_ready.
- The 400 µs timer restarts on every `fall` and is ignored in RX_IDLE when byte index is 0.
- Reset asserted mid-transfer releases both lines immediately (asynchronous) and restarts at START on deassertion.

## Configuration
- PS2_RETRY_EN defined: a handshake failure returns to START and resends INIT_CMD, up to MAX_RETRY resends. error_no_ack sets only after resend MAX_RETRY also fails. A 0xFE (resend) response counts as a failure.
- PS2_RETRY_EN undefined: the first handshake failure goes to ERROR. The retry counter is not built.

## Test plan
- Reset, device model clocks out 0xF4 frame then 0xFA -> line waveform shows clk low 150 µs, data bits 0,0,0,1,0,1,1,1,1,0 (parity 0), stop; state reaches RX_IDLE, error_no_ack=0.
- Device leaves data high on ack bit (no PS2_RETRY_EN) -> error_no_ack=1, both hiz=1; with PS2_RETRY_EN and MAX_RETRY=3 -> 4 transmissions observed, then error_no_ack=1.
- Packet 0x08,0x05,0xFB (PACKET_BYTES=3) -> packet=24'hFB0508, single data_ready pulse 2 cycles after last stop `fall`.
- Middle byte with flipped parity -> frame_error pulse, no data_ready, packet keeps previous value; next good packet accepted.
- Device stops clocking after 5 bits of byte 1 for 500 µs, then sends a full packet 0x09,0x01,0x02 -> one frame_error, then packet=24'h020109.
- PACKET_BYTES=4, bytes 0x08,0x00,0x00,0xFF -> packet=32'hFF000008, data_ready once; reset pulled low mid-packet -> all outputs at reset values asynchronously.
